branch_target_buffer: RTL and testbench

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

---
 rtl/btb_if.sv | 30 +++
 rtl/branch_target_buffer.sv | 95 +++++++++
 tb/tb_branch_target_buffer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/btb_if.sv
// Fetch/decode/branch-unit signal bundle for the branch target buffer.
interface btb_if #(
  parameter int unsigned PC_W = 32
);
  // Fetch-stage lookup
  logic [PC_W-1:0] PC;
  logic            PredictTaken;
  logic [PC_W-1:0] PredTarget;
  // Pipeline control
  logic            Stall;
  logic            Flush;
  logic            InvalidateAll;
  // Decode-stage outputs to the branch unit
  logic            PcMatchValid;
  logic [1:0]      CtrlIn;
  // Update path from the branch unit
  logic            WriteEnable;
  logic [1:0]      CtrlOut;
  logic [PC_W-1:0] BranchTarget;

  modport master (
    output PC, Stall, Flush, InvalidateAll, WriteEnable, CtrlOut, BranchTarget,
    input  PredictTaken, PredTarget, PcMatchValid, CtrlIn
  );

  modport slave (
    input  PC, Stall, Flush, InvalidateAll, WriteEnable, CtrlOut, BranchTarget,
    output PredictTaken, PredTarget, PcMatchValid, CtrlIn
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with a 2-bit predictor state per entry.
// Fetch lookup is combinational; hit/ctrl are registered into decode for the
// branch unit, which writes back through the entry addressed by the decode PC.
module branch_target_buffer #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned PC_W    = 32
) (
  input logic   clk,
  input logic   rst_n,
  btb_if.slave  bus
);

  localparam int unsigned IW = $clog2(ENTRIES);
  localparam int unsigned TW = PC_W - IW;

  // Entry storage; tag and target are only meaningful while valid is set
  logic [ENTRIES-1:0] validQ;
  logic [1:0]         ctrlQ   [ENTRIES];
  logic [TW-1:0]      tagQ    [ENTRIES];
  logic [PC_W-1:0]    targetQ [ENTRIES];

  // Decode-stage lookup register
  logic [PC_W-1:0] pcDecQ;
  logic            hitDecQ;
  logic [1:0]      ctrlDecQ;

  logic [IW-1:0]   fetchIdx;
  logic [TW-1:0]   fetchTag;
  logic            fetchHit;
  logic [1:0]      fetchCtrl;
  logic [IW-1:0]   wrIdx;
  logic [TW-1:0]   wrTag;
  logic            wrEn;

  // Fetch lookup and write addressing
  always_comb begin
    fetchIdx  = bus.PC[IW-1:0];
    fetchTag  = bus.PC[PC_W-1:IW];
    fetchHit  = validQ[fetchIdx] && (tagQ[fetchIdx] == fetchTag);
    fetchCtrl = ctrlQ[fetchIdx];
    wrIdx     = pcDecQ[IW-1:0];
    wrTag     = pcDecQ[PC_W-1:IW];
    // A stalled write is dropped; the branch unit re-presents it on release
    wrEn      = bus.WriteEnable && !bus.Stall;
  end

  assign bus.PredictTaken = fetchHit & fetchCtrl[1];
  assign bus.PredTarget   = fetchHit ? targetQ[fetchIdx] : '0;
  assign bus.PcMatchValid = hitDecQ;
  assign bus.CtrlIn       = hitDecQ ? ctrlDecQ : 2'b00;

  // Valid bits and predictor state; invalidate-all wins over a same-edge write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validQ <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctrlQ[i] <= 2'b00;
      end
    end else begin
      if (wrEn) begin
        validQ[wrIdx] <= 1'b1;
        ctrlQ[wrIdx]  <= bus.CtrlOut;
      end
      if (bus.InvalidateAll) begin
        validQ <= '0;
      end
    end
  end

  // Tag and target storage, intentionally without reset
  always_ff @(posedge clk) begin
    if (wrEn) begin
      tagQ[wrIdx]    <= wrTag;
      targetQ[wrIdx] <= bus.BranchTarget;
    end
  end

  // Decode-stage register; flush beats stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcDecQ   <= '0;
      hitDecQ  <= 1'b0;
      ctrlDecQ <= 2'b00;
    end else if (bus.Flush) begin
      pcDecQ   <= '0;
      hitDecQ  <= 1'b0;
      ctrlDecQ <= 2'b00;
    end else if (!bus.Stall) begin
      pcDecQ   <= bus.PC;
      hitDecQ  <= fetchHit;
      ctrlDecQ <= fetchCtrl;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed and randomized bench for branch_target_buffer against a table model.
module tb_branch_target_buffer;

  localparam int unsigned ENTRIES = 16;
  localparam int unsigned PC_W    = 32;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;
  int   failed;

  btb_if #(.PC_W(PC_W)) bus ();

  branch_target_buffer #(
    .ENTRIES(ENTRIES),
    .PC_W   (PC_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one record per index, tag kept as PC / ENTRIES
  bit          mValid  [ENTRIES];
  logic [31:0] mTag    [ENTRIES];
  logic [31:0] mTarget [ENTRIES];
  logic [1:0]  mCtrl   [ENTRIES];
  logic [31:0] mPcD;
  bit          mHitD;
  logic [1:0]  mCtrlD;
  bit          lkHit;
  logic [1:0]  lkCtrl;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < ENTRIES; i++) begin
      mValid[i] = 0;
      mCtrl[i]  = 2'b00;
    end
    mPcD   = 0;
    mHitD  = 0;
    mCtrlD = 2'b00;
  endtask

  // Inputs that leave every modelled state untouched across unobserved edges
  task automatic idleInputs();
    bus.PC = 0; bus.Stall = 1; bus.Flush = 0; bus.InvalidateAll = 0;
    bus.WriteEnable = 0; bus.CtrlOut = 0; bus.BranchTarget = 0;
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_taken"}, bus.PredictTaken, 0);
    check({tag, "_target"}, bus.PredTarget, 0);
    check({tag, "_match"}, bus.PcMatchValid, 0);
    check({tag, "_ctrlin"}, bus.CtrlIn, 0);
  endtask

  // Apply inputs after the falling edge and compare against the model
  task automatic drive(input logic [31:0] pc, input bit stall, input bit flush, input bit inv,
                       input bit we, input logic [1:0] co, input logic [31:0] bt);
    int unsigned idx;
    @(negedge clk);
    bus.PC = pc; bus.Stall = stall; bus.Flush = flush; bus.InvalidateAll = inv;
    bus.WriteEnable = we; bus.CtrlOut = co; bus.BranchTarget = bt;
    #1;
    idx    = pc % ENTRIES;
    lkHit  = mValid[idx] && (mTag[idx] == pc / ENTRIES);
    lkCtrl = mCtrl[idx];
    check("model_taken", bus.PredictTaken, lkHit && lkCtrl >= 2);
    check("model_target", bus.PredTarget, lkHit ? mTarget[idx] : 0);
    check("model_match", bus.PcMatchValid, mHitD);
    check("model_ctrlin", bus.CtrlIn, mHitD ? mCtrlD : 2'b00);
  endtask

  // Rising edge: retire the driven inputs into the model
  task automatic advance();
    int unsigned w;
    @(posedge clk);
    if (bus.WriteEnable && !bus.Stall) begin
      w          = mPcD % ENTRIES;
      mValid[w]  = 1;
      mTag[w]    = mPcD / ENTRIES;
      mTarget[w] = bus.BranchTarget;
      mCtrl[w]   = bus.CtrlOut;
    end
    if (bus.InvalidateAll) begin
      for (int i = 0; i < ENTRIES; i++) mValid[i] = 0;
    end
    if (bus.Flush) begin
      mPcD = 0; mHitD = 0; mCtrlD = 2'b00;
    end else if (!bus.Stall) begin
      mPcD = bus.PC; mHitD = lkHit; mCtrlD = lkCtrl;
    end
  endtask

  task automatic step(input logic [31:0] pc, input bit stall, input bit flush, input bit inv,
                      input bit we, input logic [1:0] co, input logic [31:0] bt);
    drive(pc, stall, flush, inv, we, co, bt);
    advance();
  endtask

  initial begin
    total = 0; passed = 0; failed = 0;
    idleInputs();
    rst_n = 1'b0;
    modelReset();
    #1;
    checkResetOutputs("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Cold lookup misses
    drive(32'h40, 0, 0, 0, 0, 2'b00, 0);
    check("cold_taken", bus.PredictTaken, 0);
    check("cold_match_first", bus.PcMatchValid, 0);
    advance();
    drive(32'h0, 0, 0, 0, 0, 2'b00, 0);
    check("cold_match", bus.PcMatchValid, 0);
    check("cold_ctrlin", bus.CtrlIn, 0);
    advance();

    // Install 0x40 -> 0x80 strongly taken, then hit on it
    step(32'h40, 0, 0, 0, 0, 2'b00, 0);
    step(32'h0, 0, 0, 0, 1, 2'b11, 32'h80);
    drive(32'h40, 0, 0, 0, 0, 2'b00, 0);
    check("hit_taken", bus.PredictTaken, 1);
    check("hit_target", bus.PredTarget, 32'h80);
    advance();
    drive(32'h0, 0, 0, 0, 0, 2'b00, 0);
    check("hit_match", bus.PcMatchValid, 1);
    check("hit_ctrlin", bus.CtrlIn, 2'b11);
    advance();

    // Same index, different tag
    drive(32'h50, 0, 0, 0, 0, 2'b00, 0);
    check("alias_taken", bus.PredictTaken, 0);
    check("alias_target", bus.PredTarget, 0);
    advance();
    drive(32'h0, 0, 0, 0, 0, 2'b00, 0);
    check("alias_ctrlin", bus.CtrlIn, 0);
    advance();

    // Write and lookup of one index in the same cycle: old data, then new
    step(32'h23, 0, 0, 0, 0, 2'b00, 0);
    drive(32'h23, 0, 0, 0, 1, 2'b10, 32'h99);
    check("nobypass_taken", bus.PredictTaken, 0);
    advance();
    drive(32'h23, 0, 0, 0, 0, 2'b00, 0);
    check("after_write_taken", bus.PredictTaken, 1);
    check("after_write_target", bus.PredTarget, 32'h99);
    advance();

    // Stall for three cycles with a pending write; only the release edge writes
    step(32'h17, 0, 0, 0, 0, 2'b00, 0);
    step(32'h40, 1, 0, 0, 1, 2'b11, 32'h111);
    step(32'h40, 1, 0, 0, 1, 2'b11, 32'h112);
    drive(32'h40, 1, 0, 0, 1, 2'b11, 32'h113);
    check("stall_match_held", bus.PcMatchValid, 0);
    advance();
    drive(32'h17, 0, 0, 0, 1, 2'b11, 32'h222);
    check("stall_release_old", bus.PredictTaken, 0);
    advance();
    drive(32'h17, 0, 0, 0, 0, 2'b00, 0);
    check("stall_write_target", bus.PredTarget, 32'h222);
    advance();
    drive(32'h0, 0, 0, 0, 0, 2'b00, 0);
    check("stall_write_match", bus.PcMatchValid, 1);
    advance();

    // Flush beats stall
    step(32'h40, 0, 0, 0, 0, 2'b00, 0);
    step(32'h40, 1, 1, 0, 0, 2'b00, 0);
    drive(32'h0, 0, 0, 0, 0, 2'b00, 0);
    check("flush_match", bus.PcMatchValid, 0);
    check("flush_ctrlin", bus.CtrlIn, 0);
    advance();

    // Invalidate-all overrides a simultaneous write
    step(32'h33, 0, 0, 0, 0, 2'b00, 0);
    step(32'h0, 0, 0, 1, 1, 2'b11, 32'h444);
    drive(32'h33, 0, 0, 0, 0, 2'b00, 0);
    check("inv_written_miss", bus.PredictTaken, 0);
    advance();
    drive(32'h40, 0, 0, 0, 0, 2'b00, 0);
    check("inv_old_miss", bus.PredTarget, 0);
    advance();

    // Reset asserted in the middle of a stalled write
    step(32'h40, 0, 0, 0, 0, 2'b00, 0);
    step(32'h0, 0, 0, 0, 1, 2'b11, 32'h80);
    step(32'h40, 0, 0, 0, 0, 2'b00, 0);
    drive(32'h40, 1, 0, 0, 1, 2'b11, 32'h55);
    check("pre_reset_taken", bus.PredictTaken, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midstall_reset");
    modelReset();
    idleInputs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'h40, 0, 0, 0, 0, 2'b00, 0);
    check("post_reset_taken", bus.PredictTaken, 0);
    advance();

    // Randomized traffic over a small PC pool so hits and aliases are common
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 63), ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 8),
           ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 45),
           2'($urandom_range(0, 3)), $urandom);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
